// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the serial packed-BCD add/subtract block.
//   - state_t   : sequencer states (FIX is only reachable with BCD_SIGN_MAG_EN)
//   - BCD_MAX, BCD_RADIX, BCD_CORR : decimal digit constants
//   - is_bcd()  : 1 when a 4-bit digit is a legal BCD value (0..9)
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [3:0] BCD_RADIX = 4'd10;
    localparam logic [3:0] BCD_CORR  = 4'd6;

    function automatic logic is_bcd(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// bcd_digit_alu: combinational single-digit BCD adder/subtractor.
//   a_d  in  4  addend digit
//   b_d  in  4  second operand digit (nine's-complemented when sub=1)
//   cin  in  1  incoming decimal carry
//   sub  in  1  select nine's complement of b_d
//   s_d  out 4  corrected BCD sum digit
//   cout out 1  outgoing decimal carry
module bcd_digit_alu
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] s_d,
    output logic       cout
);

    logic [3:0] bd;
    logic [4:0] sum;
    logic [4:0] corr;

    always_comb begin
        bd   = sub ? (BCD_MAX - b_d) : b_d;
        sum  = {1'b0, a_d} + {1'b0, bd} + {4'b0000, cin};
        // Adding 6 and dropping bit 4 is the same as subtracting 10.
        corr = sum + {1'b0, BCD_CORR};
        if (sum >= {1'b0, BCD_RADIX}) begin
            s_d  = corr[3:0];
            cout = 1'b1;
        end else begin
            s_d  = sum[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub_ctrl.sv
// bcd_serial_addsub_ctrl: multi-digit packed-BCD add/subtract sequencer.
// Operands are captured on start and walked LSD-first, one digit per clock,
// through one shared bcd_digit_alu. Subtraction is A + 9's(B) + 1.
// Optional macro BCD_SIGN_MAG_EN: adds output neg and a FIX pass that turns a
// negative 10's-complement difference into its magnitude.
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request, sampled only in IDLE
//   sub       in   0 = A+B, 1 = A-B (captured with start)
//   a, b      in   packed BCD operands, digit 0 in bits [3:0]
//   busy      out  high while an operation is in flight (incl. DONE cycle)
//   done      out  one-cycle result-valid pulse
//   result    out  BCD result, held until the next accepted start
//   carry_out out  add: decimal overflow; sub: 1 means A >= B
//   err       out  a captured digit was > 9
//   neg       out  (BCD_SIGN_MAG_EN only) result is a negative magnitude
module bcd_serial_addsub_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                carry_out,
`ifdef BCD_SIGN_MAG_EN
    output logic                neg,
`endif
    output logic                err
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

    state_t              state;
    logic [IDXW-1:0]     idx;
    logic                carry;
    logic [4*DIGITS-1:0] opa;
    logic [4*DIGITS-1:0] opb;
    logic                opsub;

    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_sub;
    logic [3:0] alu_s;
    logic       alu_c;
    logic       cap_err;

    // FIX reuses the datapath as 0 - result, i.e. the 10's complement.
    always_comb begin
        if (state == FIX) begin
            alu_a   = 4'd0;
            alu_b   = result[{idx, 2'b00} +: 4];
            alu_sub = 1'b1;
        end else begin
            alu_a   = opa[{idx, 2'b00} +: 4];
            alu_b   = opb[{idx, 2'b00} +: 4];
            alu_sub = opsub;
        end
    end

    always_comb begin
        cap_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(a[i*4 +: 4]) || !is_bcd(b[i*4 +: 4]))
                cap_err = 1'b1;
        end
    end

    bcd_digit_alu u_alu (
        .a_d  (alu_a),
        .b_d  (alu_b),
        .cin  (carry),
        .sub  (alu_sub),
        .s_d  (alu_s),
        .cout (alu_c)
    );

    // Operand registers carry no reset; they are only read after a capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            opa   <= a;
            opb   <= b;
            opsub <= sub;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            err       <= 1'b0;
`ifdef BCD_SIGN_MAG_EN
            neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        carry     <= sub;
                        idx       <= '0;
                        err       <= cap_err;
                        result    <= '0;
                        carry_out <= 1'b0;
                        busy      <= 1'b1;
`ifdef BCD_SIGN_MAG_EN
                        neg       <= 1'b0;
`endif
                        state     <= ADD;
                    end
                end
                ADD: begin
                    result[{idx, 2'b00} +: 4] <= alu_s;
                    carry <= alu_c;
                    if (idx == LAST) begin
                        idx       <= '0;
                        carry_out <= alu_c;
`ifdef BCD_SIGN_MAG_EN
                        if (opsub && !alu_c) begin
                            // Negative difference: FIX needs carry-in 1 for 0 - x.
                            carry <= 1'b1;
                            state <= FIX;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
`else
                        done  <= 1'b1;
                        state <= DONE;
`endif
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                FIX: begin
                    result[{idx, 2'b00} +: 4] <= alu_s;
                    carry <= alu_c;
                    if (idx == LAST) begin
                        idx   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef BCD_SIGN_MAG_EN
                        neg   <= 1'b1;
`endif
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
